// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, drives a variable-latency instruction-memory handshake, holds a
// fetched instruction across hazard stalls and discards fetches made stale by
// branch/jump redirects from decode.
//
// Memory handshake: imem_req is the request valid, imem_addr its payload. Once
// imem_req is high, imem_addr is held stable until a cycle in which imem_ready
// is high; that cycle transfers imem_rdata and completes the request. imem_req
// only falls without imem_ready when rst abandons an outstanding request.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              StallF,
    input  logic              PCSrcD,
    input  logic [ADDR_W-1:0] PCBranchD,
    input  logic              JumpD,
    input  logic [ADDR_W-1:0] PCJumpD,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       RDF,
    output logic [ADDR_W-1:0] PCPlus4F,
    output logic [ADDR_W-1:0] PCF,
    output logic              FetchBusyF,
    output logic [1:0]        dbg_state
);

    // FETCH: request outstanding at PCF
    // DROP : response still owed for a stale address; discard it, then redirect
    // HOLD : instruction captured during a stall; no request outstanding
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       hold_q, hold_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    logic              redirect;
    logic [ADDR_W-1:0] sel_target;

    assign PCF       = pc_q;
    assign PCPlus4F  = pc_q + ADDR_W'(4);
    assign imem_addr = pc_q;
    assign dbg_state = state_q;

    // Redirects are only honoured while fetch is not stalled; decode re-presents
    // them once the stall drops. Jump takes priority over branch.
    assign redirect   = (JumpD | PCSrcD) & ~StallF;
    assign sel_target = JumpD ? PCJumpD : PCBranchD;

    // State, PC, hold buffer and latched redirect target registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state, next-PC and output decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        tgt_d      = tgt_q;
        imem_req   = 1'b0;
        RDF        = 32'h0;
        FetchBusyF = 1'b1;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (redirect) begin
                        // Fetched word belongs to the wrong path: drop it
                        pc_d = sel_target;
                    end else if (StallF) begin
                        // Valid instruction, but decode cannot take a new one
                        // yet: park it and stop requesting
                        RDF        = imem_rdata;
                        FetchBusyF = 1'b0;
                        hold_d     = imem_rdata;
                        state_d    = HOLD;
                    end else begin
                        RDF        = imem_rdata;
                        FetchBusyF = 1'b0;
                        pc_d       = PCPlus4F;
                    end
                end else if (redirect) begin
                    // Cannot retract the request; remember where to go
                    tgt_d   = sel_target;
                    state_d = DROP;
                end
            end

            DROP: begin
                imem_req = 1'b1;
                if (redirect) begin
                    tgt_d = sel_target;
                end
                if (imem_ready) begin
                    pc_d    = redirect ? sel_target : tgt_q;
                    state_d = FETCH;
                end
            end

            HOLD: begin
                RDF        = hold_q;
                FetchBusyF = 1'b0;
                if (!StallF) begin
                    state_d = FETCH;
                    if (redirect) begin
                        pc_d   = sel_target;
                        hold_d = 32'h0;
                    end else begin
                        pc_d = PCPlus4F;
                    end
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // No request and no instruction while reset is asserted
        if (rst) begin
            imem_req   = 1'b0;
            RDF        = 32'h0;
            FetchBusyF = 1'b1;
        end
    end

endmodule
